// File: rtl/matmul_input_feeder_os_pkg.sv
// Shared definitions for the output-stationary input feeder: FSM states,
// default geometry, stream-length helpers and flattened-matrix index helpers.
package matmul_input_feeder_os_pkg;

  typedef enum logic [1:0] {IDLE, CLEAR, STREAM, DONE} state_t;

  localparam int unsigned DEF_ROWS   = 4;
  localparam int unsigned DEF_COLS   = 4;
  localparam int unsigned DEF_INNER  = 4;
  localparam int unsigned STREAM_LEN = DEF_INNER + DEF_ROWS + DEF_COLS - 2;
  localparam int unsigned CNT_W      = $clog2(STREAM_LEN + 1);

  // Number of STREAM cycles needed to fully skew A and B through the array.
  function automatic int unsigned stream_len(int unsigned rows, int unsigned cols,
                                             int unsigned inner);
    return inner + rows + cols - 2;
  endfunction

  function automatic int unsigned cnt_width(int unsigned rows, int unsigned cols,
                                            int unsigned inner);
    return $clog2(stream_len(rows, cols, inner) + 1);
  endfunction

  // Element index of A[r][k] in the flattened a_matrix (row-major).
  function automatic int unsigned a_idx(int unsigned r, int unsigned k, int unsigned inner);
    return r * inner + k;
  endfunction

  // Element index of B[k][c] in the flattened b_matrix (row-major).
  function automatic int unsigned b_idx(int unsigned k, int unsigned c, int unsigned cols);
    return k * cols + c;
  endfunction

endpackage

// File: rtl/matmul_input_feeder_os_lane.sv
// One skewed edge lane: lane LANE carries element (t - LANE) of its INNER
// latched operands while 0 <= t - LANE < INNER, otherwise zero data / no valid.
module matmul_skew_lane #(
  parameter int unsigned INNER     = 4,
  parameter int unsigned WORD_SIZE = 16,
  parameter int unsigned CNT_W     = 4,
  parameter int unsigned LANE      = 0
) (
  input  logic [CNT_W-1:0]           t,
  input  logic                       en,
  input  logic [INNER*WORD_SIZE-1:0] elems,
  output logic [WORD_SIZE-1:0]       data,
  output logic                       valid
);

  int unsigned ti;

  // Select the skewed element for this lane at step t.
  always_comb begin
    data  = '0;
    valid = 1'b0;
    ti    = 32'(t);
    if (en && ti >= LANE && ti < LANE + INNER) begin
      valid = 1'b1;
      data  = elems[(ti - LANE) * WORD_SIZE +: WORD_SIZE];
    end
  end

endmodule

// File: rtl/matmul_input_feeder_os.sv
// Input feeder for an output-stationary systolic array: latches A and B on
// start, streams them skewed into the left/top edges and streams unskewed
// operand pairs to every redundant unit covering a faulty PE.
module matmul_input_feeder_os
  import matmul_input_feeder_os_pkg::*;
#(
  parameter int unsigned ROWS      = DEF_ROWS,
  parameter int unsigned COLS      = DEF_COLS,
  parameter int unsigned INNER     = DEF_INNER,
  parameter int unsigned WORD_SIZE = 16,
  parameter int unsigned NUM_RU    = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  output logic                                ready,
  input  logic [ROWS*INNER*WORD_SIZE-1:0]     a_matrix,
  input  logic [INNER*COLS*WORD_SIZE-1:0]     b_matrix,
  input  logic [ROWS*COLS-1:0]                STW_result_mat,
  input  logic [$clog2(ROWS)*NUM_RU-1:0]      ru_row_mapping,
  input  logic [$clog2(COLS)*NUM_RU-1:0]      ru_col_mapping,
  output logic                                acc_clear,
  output logic [ROWS*WORD_SIZE-1:0]           left_in,
  output logic [ROWS-1:0]                     left_valid,
  output logic [COLS*WORD_SIZE-1:0]           top_in,
  output logic [COLS-1:0]                     top_valid,
  output logic [NUM_RU*WORD_SIZE-1:0]         ru_a_out,
  output logic [NUM_RU*WORD_SIZE-1:0]         ru_b_out,
  output logic [NUM_RU-1:0]                   ru_in_valid,
  output logic [NUM_RU-1:0]                   ru_active,
  output logic                                done
);

  localparam int unsigned T_LEN = stream_len(ROWS, COLS, INNER);
  localparam int unsigned TW    = cnt_width(ROWS, COLS, INNER);
  localparam int unsigned RW    = $clog2(ROWS);
  localparam int unsigned CLW   = $clog2(COLS);
  localparam int unsigned W     = WORD_SIZE;

  state_t                        state, state_n;
  logic [TW-1:0]                 t, t_n;
  logic [ROWS*INNER*W-1:0]       a_q;
  logic [INNER*COLS*W-1:0]       b_q;
  logic [RW*NUM_RU-1:0]          row_q;
  logic [CLW*NUM_RU-1:0]         col_q;
  logic [NUM_RU-1:0]             act_n;
  logic                          streaming_n;
  logic [ROWS*W-1:0]             left_nx;
  logic [ROWS-1:0]               lv_nx;
  logic [COLS*W-1:0]             top_nx;
  logic [COLS-1:0]               tv_nx;
  logic [NUM_RU*W-1:0]           ra_nx, rb_nx;
  logic [NUM_RU-1:0]             rv_nx;

  // Next-state and step-counter logic.
  always_comb begin
    state_n = state;
    t_n     = t;
    case (state)
      IDLE:   if (start) state_n = CLEAR;
      CLEAR:  begin state_n = STREAM; t_n = '0; end
      STREAM: if (t == TW'(T_LEN - 1)) state_n = DONE;
              else t_n = t + 1'b1;
      DONE:   begin state_n = IDLE; t_n = '0; end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from the next state/step so they line up with the
  // state they describe; enumerating PE positions keeps out-of-range mappings
  // from ever matching, which forces their RU inactive.
  always_comb begin
    act_n = '0;
    for (int unsigned i = 0; i < NUM_RU; i++)
      for (int unsigned p = 0; p < ROWS * COLS; p++)
        if (32'(ru_row_mapping[i*RW +: RW]) == p / COLS &&
            32'(ru_col_mapping[i*CLW +: CLW]) == p % COLS)
          act_n[i] = ~STW_result_mat[p];
  end

  assign streaming_n = (state_n == STREAM);

  for (genvar r = 0; r < ROWS; r++) begin : g_a_lane
    matmul_skew_lane #(.INNER(INNER), .WORD_SIZE(W), .CNT_W(TW), .LANE(r)) u_lane (
      .t(t_n), .en(streaming_n),
      .elems(a_q[a_idx(r, 0, INNER)*W +: INNER*W]),
      .data(left_nx[r*W +: W]), .valid(lv_nx[r])
    );
  end

  for (genvar c = 0; c < COLS; c++) begin : g_b_lane
    logic [INNER*W-1:0] col_elems;
    for (genvar k = 0; k < INNER; k++) begin : g_gather
      assign col_elems[k*W +: W] = b_q[b_idx(k, c, COLS)*W +: W];
    end
    matmul_skew_lane #(.INNER(INNER), .WORD_SIZE(W), .CNT_W(TW), .LANE(c)) u_lane (
      .t(t_n), .en(streaming_n), .elems(col_elems),
      .data(top_nx[c*W +: W]), .valid(tv_nx[c])
    );
  end

  // Unskewed operand pair for each active RU during the first INNER steps.
  always_comb begin
    ra_nx = '0;
    rb_nx = '0;
    rv_nx = '0;
    if (streaming_n && 32'(t_n) < INNER) begin
      for (int unsigned i = 0; i < NUM_RU; i++) begin
        if (ru_active[i]) begin
          rv_nx[i] = 1'b1;
          for (int unsigned r = 0; r < ROWS; r++)
            if (32'(row_q[i*RW +: RW]) == r)
              ra_nx[i*W +: W] = a_q[a_idx(r, 32'(t_n), INNER)*W +: W];
          for (int unsigned c = 0; c < COLS; c++)
            if (32'(col_q[i*CLW +: CLW]) == c)
              rb_nx[i*W +: W] = b_q[b_idx(32'(t_n), c, COLS)*W +: W];
        end
      end
    end
  end

  // State, counter, job snapshot and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      t           <= '0;
      a_q         <= '0;
      b_q         <= '0;
      row_q       <= '0;
      col_q       <= '0;
      ru_active   <= '0;
      ready       <= 1'b1;
      acc_clear   <= 1'b0;
      done        <= 1'b0;
      left_in     <= '0;
      left_valid  <= '0;
      top_in      <= '0;
      top_valid   <= '0;
      ru_a_out    <= '0;
      ru_b_out    <= '0;
      ru_in_valid <= '0;
    end else begin
      state <= state_n;
      t     <= t_n;
      if (state == IDLE && start) begin
        a_q       <= a_matrix;
        b_q       <= b_matrix;
        row_q     <= ru_row_mapping;
        col_q     <= ru_col_mapping;
        ru_active <= act_n;
      end
      ready       <= (state_n == IDLE);
      acc_clear   <= (state_n == CLEAR);
      done        <= (state_n == DONE);
      left_in     <= left_nx;
      left_valid  <= lv_nx;
      top_in      <= top_nx;
      top_valid   <= tv_nx;
      ru_a_out    <= ra_nx;
      ru_b_out    <= rb_nx;
      ru_in_valid <= rv_nx;
    end
  end

endmodule
